// File: rtl/display_pkg.sv
// Shared display types and constants for the VGA pixel pipeline.
// Screen-state encoding and the 12-bit colour layout live here.
package display_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    ARMED   = 2'd1,
    PLAY    = 2'd2,
    LEAVING = 2'd3
  } screen_state_t;

  // The game owns the screen from PLAY until the frame boundary that ends LEAVING.
  function automatic logic is_game_state(screen_state_t s);
    return (s == PLAY) || (s == LEAVING);
  endfunction

endpackage

// File: rtl/start_screen_ctrl_if.sv
// Pixel-stream bundle between the timing/text/game sources and the start-screen stage.
// The slave modport is the start-screen controller; master is whoever drives the pixel stream.
interface start_screen_ctrl_if;
  import display_pkg::*;

  logic [COORD_W-1:0] sx;
  logic [COORD_W-1:0] sy;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic               frame;
  logic               text_pixel;
  logic [11:0]        game_rgb;
  logic               start_btn;
  logic               game_over;
  logic [COORD_W-1:0] text_x;
  logic [COORD_W-1:0] text_y;
  logic               game_active;
  logic [11:0]        vga_rgb;
  logic               vga_hsync;
  logic               vga_vsync;

  modport slave (
    input  sx, sy, de, hsync, vsync, frame, text_pixel, game_rgb, start_btn, game_over,
    output text_x, text_y, game_active, vga_rgb, vga_hsync, vga_vsync
  );

  modport master (
    output sx, sy, de, hsync, vsync, frame, text_pixel, game_rgb, start_btn, game_over,
    input  text_x, text_y, game_active, vga_rgb, vga_hsync, vga_vsync
  );

endinterface

// File: rtl/start_screen_ctrl_btn_sync.sv
// Two-flop synchroniser for an asynchronous push button, with a registered
// one-cycle rising-edge pulse (input edge to pulse: 3 clocks).
module btn_sync (
  input  logic clk_pix,
  input  logic rst_pix,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;

endmodule

// File: rtl/start_screen_ctrl.sv
// Start-screen stage: blinking "PRESS START" attract screen, hand-over to the game
// on frame boundaries, and a single register stage driving colour and syncs to the pins.
module start_screen_ctrl
  import display_pkg::*;
#(
  parameter logic [COORD_W-1:0] TEXT_X       = 10'd285,
  parameter logic [COORD_W-1:0] TEXT_Y       = 10'd236,
  parameter int                 BLINK_FRAMES = 30,
  parameter logic [11:0]        FG_RGB       = 12'hFFF,
  parameter logic [11:0]        BG_RGB       = 12'h008
) (
  input logic                clk_pix,
  input logic                rst_pix,
  start_screen_ctrl_if.slave bus
);

  localparam int             CW      = $clog2(BLINK_FRAMES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_FRAMES - 1);

  logic start_evt;

  btn_sync u_btn_sync (
    .clk_pix  (clk_pix),
    .rst_pix  (rst_pix),
    .async_in (bus.start_btn),
    .level    (),
    .rise     (start_evt)
  );

  screen_state_t state_q, state_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  rgb_t          rgb_q, rgb_d;
  logic          hsync_q, vsync_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ATTRACT: if (start_evt)     state_d = ARMED;
      ARMED:   if (bus.frame)     state_d = PLAY;
      PLAY:    if (bus.game_over) state_d = LEAVING;
      LEAVING: if (bus.frame)     state_d = ATTRACT;
      default:                    state_d = ATTRACT;
    endcase
  end

  // Returning to ATTRACT restarts the blink with the text visible; PLAY freezes it.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (bus.frame && state_q == LEAVING) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (bus.frame && state_q != PLAY) begin
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Colour uses the next-state values so the frame-pulse pixel already shows the new screen.
  always_comb begin
    rgb_d = '0;
    if (bus.de) begin
      if (is_game_state(state_d)) begin
        rgb_d = bus.game_rgb;
      end else begin
        rgb_d = (bus.text_pixel && blink_on_d) ? FG_RGB : BG_RGB;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q     <= ATTRACT;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      rgb_q       <= rgb_d;
      hsync_q     <= bus.hsync;
      vsync_q     <= bus.vsync;
    end
  end

  assign bus.text_x      = TEXT_X;
  assign bus.text_y      = TEXT_Y;
  assign bus.game_active = is_game_state(state_q);
  assign bus.vga_rgb     = rgb_q;
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Directed bench for start_screen_ctrl with BLINK_FRAMES=2: attract colours, blink,
// start/game-over hand-over on frame boundaries, sync alignment and async reset.
module tb_start_screen_ctrl;

  logic clk_pix = 1'b0;
  logic rst_pix;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_pix = ~clk_pix;

  start_screen_ctrl_if bus ();

  start_screen_ctrl #(
    .TEXT_X       (10'd285),
    .TEXT_Y       (10'd236),
    .BLINK_FRAMES (2),
    .FG_RGB       (12'hFFF),
    .BG_RGB       (12'h008)
  ) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .bus     (bus)
  );

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel: drive inputs, clock once, return 1 time unit after the edge.
  task automatic applyStimulus(input logic de, input logic tp, input logic fr,
                               input logic go, input logic [11:0] grgb);
    bus.de         = de;
    bus.text_pixel = tp;
    bus.frame      = fr;
    bus.game_over  = go;
    bus.game_rgb   = grgb;
    bus.sx         = fr ? 10'd0 : 10'd300;
    bus.sy         = fr ? 10'd0 : 10'd240;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic checkPixel(input string tag, input logic [11:0] rgb, input logic active);
    checkOutput({tag, "_rgb"}, bus.vga_rgb, rgb);
    checkOutput({tag, "_active"}, {11'd0, bus.game_active}, {11'd0, active});
  endtask

  initial begin
    logic       h, v, d;
    logic [11:0] g;

    rst_pix        = 1'b1;
    bus.sx         = '0;
    bus.sy         = '0;
    bus.de         = 1'b0;
    bus.hsync      = 1'b1;
    bus.vsync      = 1'b1;
    bus.frame      = 1'b0;
    bus.text_pixel = 1'b0;
    bus.game_rgb   = '0;
    bus.start_btn  = 1'b0;
    bus.game_over  = 1'b0;

    #3;
    checkOutput("rst_rgb", bus.vga_rgb, 12'h000);
    checkOutput("rst_hsync", {11'd0, bus.vga_hsync}, 12'd1);
    checkOutput("rst_vsync", {11'd0, bus.vga_vsync}, 12'd1);
    checkOutput("rst_active", {11'd0, bus.game_active}, 12'd0);
    checkOutput("text_x", {2'b00, bus.text_x}, 12'd285);
    checkOutput("text_y", {2'b00, bus.text_y}, 12'd236);
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_pix = 1'b0;

    // Attract colours: text, background, blanking.
    applyStimulus(1, 1, 0, 0, 12'h123); checkPixel("attr_text", 12'hFFF, 0);
    applyStimulus(1, 0, 0, 0, 12'h123); checkPixel("attr_bg", 12'h008, 0);
    applyStimulus(0, 1, 0, 0, 12'h123); checkPixel("attr_blank", 12'h000, 0);

    // Blink with 2-frame half period: on, on, off, off, on, on, off.
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f1", 12'hFFF, 0);
    applyStimulus(1, 1, 0, 0, 0); checkPixel("blink_f1b", 12'hFFF, 0);
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f2", 12'h008, 0);
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f3", 12'h008, 0);
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f4", 12'hFFF, 0);
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f5", 12'hFFF, 0);
    applyStimulus(1, 1, 1, 0, 0); checkPixel("blink_f6", 12'h008, 0);

    // Start mid-frame: ARMED until the next frame pulse, then game colour.
    bus.start_btn = 1'b1;
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("mid_c1", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("mid_c2", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("mid_c3", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("mid_armed", 12'h008, 0);
    bus.start_btn = 1'b0;
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("mid_wait", 12'h008, 0);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("mid_play", 12'h0F0, 1);
    applyStimulus(0, 1, 0, 0, 12'h0F0); checkPixel("play_blank", 12'h000, 1);

    // Game over: LEAVING keeps the game on screen until the frame boundary.
    applyStimulus(1, 1, 0, 1, 12'h0F0); checkPixel("go_leaving", 12'h0F0, 1);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("go_wait", 12'h0F0, 1);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("go_attract", 12'hFFF, 0);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("go_cnt1", 12'hFFF, 0);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("go_cnt_wrap", 12'h008, 0);
    applyStimulus(1, 1, 0, 1, 12'h0F0); checkPixel("go_ignored", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("go_ignored2", 12'h008, 0);

    // Start event coincident with frame: PLAY only on the following frame.
    bus.start_btn = 1'b1;
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("co_c1", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("co_c2", 12'h008, 0);
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("co_c3", 12'h008, 0);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("co_frame", 12'h008, 0);
    bus.start_btn = 1'b0;
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("co_armed", 12'h008, 0);
    applyStimulus(1, 1, 1, 0, 12'h0F0); checkPixel("co_play", 12'h0F0, 1);

    // Sync/colour alignment in PLAY with random patterns: exactly one cycle delay.
    for (int i = 0; i < 24; i++) begin
      h = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      g = 12'($urandom_range(0, 4095));
      bus.hsync = h;
      bus.vsync = v;
      applyStimulus(d, 0, 0, 0, g);
      checkOutput("sync_h", {11'd0, bus.vga_hsync}, {11'd0, h});
      checkOutput("sync_v", {11'd0, bus.vga_vsync}, {11'd0, v});
      checkOutput("sync_rgb", bus.vga_rgb, d ? g : 12'h000);
    end

    // Asynchronous reset mid-line.
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    applyStimulus(1, 0, 0, 0, 12'hFFF);
    checkOutput("pre_rst_h", {11'd0, bus.vga_hsync}, 12'd0);
    checkOutput("pre_rst_rgb", bus.vga_rgb, 12'hFFF);
    #2 rst_pix = 1'b1;
    #1;
    checkOutput("async_rst_h", {11'd0, bus.vga_hsync}, 12'd1);
    checkOutput("async_rst_v", {11'd0, bus.vga_vsync}, 12'd1);
    checkOutput("async_rst_rgb", bus.vga_rgb, 12'h000);
    checkOutput("async_rst_active", {11'd0, bus.game_active}, 12'd0);
    @(negedge clk_pix);
    rst_pix   = 1'b0;
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    applyStimulus(1, 1, 0, 0, 12'h0F0); checkPixel("post_rst", 12'hFFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
